// File: rtl/fpu_issue_ctrl.sv
// Issue controller between decode and the FP units: one op in flight, fixed-latency wait,
// registered response. Optional performance counters under `FPU_ISSUE_PERF_EN`.
module fpu_issue_ctrl #(
  parameter int unsigned MULTI_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_s,
  input  logic [31:0] req_t,
  input  logic [4:0]  req_rd,
  output logic [5:0]  fpu_funct,
  output logic [31:0] fpu_s,
  output logic [31:0] fpu_t,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal,
  output logic        busy,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy_cycles
);

  localparam logic [5:0] F_ADD  = 6'b000000, F_SUB = 6'b000001, F_MUL = 6'b000010,
                         F_SQRT = 6'b000100, F_INV = 6'b000011, F_EQ  = 6'b110010,
                         F_LT   = 6'b110100, F_LE  = 6'b110110, F_FTOI = 6'b001000,
                         F_ITOF = 6'b001001, F_ABS = 6'b000101, F_NEG = 6'b000111;
  localparam logic [3:0] MULTI_M1 = 4'(MULTI_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  funct_q;
  logic [31:0] s_q, t_q, rsp_data_q, result_d;
  logic [4:0]  rd_q, rsp_rd_q;
  logic        rsp_illegal_q, illegal_d;
  logic        accept, capture;
  logic [3:0]  lat_m1;

  function automatic logic is_multi(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_MUL) || (f == F_SQRT);
  endfunction

  function automatic logic is_single(input logic [5:0] f);
    return (f == F_INV) || (f == F_EQ) || (f == F_LT) || (f == F_LE) ||
           (f == F_FTOI) || (f == F_ITOF);
  endfunction

  assign req_ready = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign lat_m1    = is_multi(req_funct) ? MULTI_M1 : 4'd0;

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          cnt_d   = lat_m1;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = accept ? EXEC : IDLE;
          if (accept) cnt_d = lat_m1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result source for the op currently held on the fpu_* lines.
  always_comb begin
    result_d  = 32'd0;
    illegal_d = 1'b0;
    if (funct_q == F_ABS) begin
      result_d = {1'b0, s_q[30:0]};
    end else if (funct_q == F_NEG) begin
      result_d = {~s_q[31], s_q[30:0]};
    end else if (is_multi(funct_q) || is_single(funct_q)) begin
      result_d = fpu_result;
    end else begin
      illegal_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      funct_q       <= 6'd0;
      s_q           <= 32'd0;
      t_q           <= 32'd0;
      rd_q          <= 5'd0;
      rsp_data_q    <= 32'd0;
      rsp_rd_q      <= 5'd0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        funct_q <= req_funct;
        s_q     <= req_s;
        t_q     <= req_t;
        rd_q    <= req_rd;
      end
      if (capture) begin
        rsp_data_q    <= result_d;
        rsp_rd_q      <= rd_q;
        rsp_illegal_q <= illegal_d;
      end
    end
  end

  assign fpu_funct   = funct_q;
  assign fpu_s       = s_q;
  assign fpu_t       = t_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_illegal = rsp_illegal_q;
  assign busy        = (state_q != IDLE);

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_ops_q, perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      if (accept) perf_ops_q <= perf_ops_q + 32'd1;
      if (state_q != IDLE) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_ops         = perf_ops_q;
  assign perf_busy_cycles = perf_busy_q;
`else
  assign perf_ops         = 32'd0;
  assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed cases plus randomized ops against a
// transaction-level model of latency and result per function class.
module tb_fpu_issue_ctrl;
  localparam int MULTI_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [5:0]  req_funct = '0;
  logic [31:0] req_s = '0, req_t = '0;
  logic [4:0]  req_rd = '0;
  logic [5:0]  fpu_funct;
  logic [31:0] fpu_s, fpu_t, fpu_result;
  logic        rsp_valid, rsp_illegal, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [31:0] perf_ops, perf_busy_cycles;

  logic        use_const = 1'b0;
  logic [31:0] const_val = 32'h40C0_0000;

  int errors = 0;
  int checks = 0;

  fpu_issue_ctrl #(.MULTI_LAT(MULTI_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_s(req_s), .req_t(req_t), .req_rd(req_rd),
    .fpu_funct(fpu_funct), .fpu_s(fpu_s), .fpu_t(fpu_t), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_illegal(rsp_illegal), .busy(busy), .perf_ops(perf_ops),
    .perf_busy_cycles(perf_busy_cycles)
  );

  always #5 clk = ~clk;

  // Stand-in FP units: any deterministic function of the presented operands.
  function automatic logic [31:0] fpu_model(input logic [5:0] f, input logic [31:0] s,
                                            input logic [31:0] t);
    return (s * 32'd3) ^ t ^ {26'd0, f};
  endfunction

  assign fpu_result = use_const ? const_val : fpu_model(fpu_funct, fpu_s, fpu_t);

  // Reference model: classify the code and derive latency / result from the rules.
  function automatic int ref_class(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000001, 6'b000010, 6'b000100: return 0;  // multi-cycle
      6'b000011, 6'b110010, 6'b110100, 6'b110110, 6'b001000, 6'b001001: return 1;
      6'b000101: return 2;  // abs
      6'b000111: return 3;  // neg
      default: return 4;    // illegal
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] f);
    return (ref_class(f) == 0) ? MULTI_LAT : 1;
  endfunction

  function automatic logic [31:0] ref_data(input logic [5:0] f, input logic [31:0] s,
                                           input logic [31:0] t);
    case (ref_class(f))
      0, 1: return use_const ? const_val : fpu_model(f, s, t);
      2: return s & 32'h7FFF_FFFF;
      3: return s ^ 32'h8000_0000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic accept_idle(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t,
                             input logic [4:0] rd);
    req_funct = f; req_s = s; req_t = t; req_rd = rd; req_valid = 1'b1;
    #1 check("ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_funct = 6'($urandom); req_s = $urandom; req_t = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic wait_rsp(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t,
                          input logic [4:0] rd);
    int k = 0;
    while (!rsp_valid && k < 20) begin
      check("fpu_funct_hold", 32'(fpu_funct), 32'(f));
      check("fpu_s_hold", fpu_s, s);
      check("fpu_t_hold", fpu_t, t);
      check("busy_exec", 32'(busy), 32'd1);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(ref_lat(f)));
    check("rsp_data", rsp_data, ref_data(f, s, t));
    check("rsp_rd", 32'(rsp_rd), 32'(rd));
    check("rsp_illegal", 32'(rsp_illegal), 32'(ref_class(f) == 4));
  endtask

  // Hold the response for `stall` cycles with a blocked request, then complete the handshake.
  task automatic drain(input int stall, input logic [31:0] s);
    logic [31:0] held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'($urandom);
      #1 check("ready_stall", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rsp_hold", rsp_data, held);
      check("valid_hold", 32'(rsp_valid), 32'd1);
      check("fpu_s_stall", fpu_s, s);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
    check("busy_after_hs", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t,
                        input logic [4:0] rd, input int stall);
    accept_idle(f, s, t, rd);
    wait_rsp(f, s, t, rd);
    drain(stall, s);
  endtask

  initial begin
    logic [5:0]  codes [12] = '{6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b000011,
                                6'b110010, 6'b110100, 6'b110110, 6'b001000, 6'b001001,
                                6'b000101, 6'b000111};
    logic [31:0] a_s, b_s;
    int          n, guard;

    // Reset with a pending request: everything quiet, no acceptance.
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fpu_s", fpu_s, 32'd0);
    check("rst_fpu_funct", 32'(fpu_funct), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_perf_ops", perf_ops, 32'd0);
    check("rst_perf_busy", perf_busy_cycles, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);
    @(negedge clk);

    // MUL with a fixed FPU result.
    use_const = 1'b1;
    run_op(6'b000010, 32'h4000_0000, 32'h4040_0000, 5'd7, 0);
    use_const = 1'b0;

    // Internal ops and an illegal code.
    run_op(6'b000111, 32'h3F80_0000, 32'h1234_5678, 5'd3, 0);
    run_op(6'b000101, 32'hC000_0000, 32'h0, 5'd4, 1);
    run_op(6'b111111, 32'hDEAD_BEEF, 32'h1, 5'd31, 2);

    // Back-pressure with a second request pending, accepted on the handshake cycle.
    a_s = $urandom;
    b_s = $urandom;
    accept_idle(6'b000000, a_s, 32'h55, 5'd9);
    wait_rsp(6'b000000, a_s, 32'h55, 5'd9);
    req_funct = 6'b000111; req_s = b_s; req_t = 32'h0; req_rd = 5'd12; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("b2b_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("b2b_rsp_hold", rsp_data, ref_data(6'b000000, a_s, 32'h55));
      check("b2b_rd_hold", 32'(rsp_rd), 32'd9);
    end
    rsp_ready = 1'b1;
    #1 check("b2b_ready_high", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_rsp(6'b000111, b_s, 32'h0, 5'd12);
    drain(0, b_s);

    // Randomized ops.
    for (int i = 0; i < 150; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 15) < 12) ? codes[$urandom_range(0, 11)] : 6'($urandom);
      run_op(f, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    // Reset mid-EXEC of SQRT discards the op.
    accept_idle(6'b000100, 32'h4080_0000, 32'h0, 5'd2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec_valid", 32'(rsp_valid), 32'd0);
      check("rst_exec_busy", 32'(busy), 32'd0);
      check("rst_exec_fpu_s", fpu_s, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < MULTI_LAT + 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
    end

    // Four back-to-back ADDs for the performance counters.
    do_reset();
    n = 0;
    guard = 0;
    req_funct = 6'b000000; req_s = $urandom; req_t = $urandom; req_rd = 5'd1;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    while (n < 4 && guard < 100) begin
      #1 if (req_ready) n++;
      @(negedge clk);
      req_s = $urandom;
      guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("perf_drained", 32'(busy), 32'd0);
`ifdef FPU_ISSUE_PERF_EN
    check("perf_ops", perf_ops, 32'd4);
    check("perf_busy", perf_busy_cycles, 32'd4 * 32'(MULTI_LAT + 1));
`else
    check("perf_ops_off", perf_ops, 32'd0);
    check("perf_busy_off", perf_busy_cycles, 32'd0);
`endif
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
